router_sync_param: RTL and testbench
====================================

Name: router_sync_param

Overview:
Parametrised successor of the 3-port router synchroniser. Sits between the router FSM and NUM_PORTS output FIFOs. It latches the destination address and steers the FSM write strobe to one FIFO. It reports the selected FIFO's full flag and derives per-port valid flags. It issues a per-port soft reset when a port's valid data is left unread for TIMEOUT cycles. New behaviour: arbitrary port count, configurable timeout, and invalid-address detection with write suppression.

Parameters:
NUM_PORTS, 3, number of output FIFOs/ports (2..16)
ADDR_W, $clog2(NUM_PORTS) (min 1), width of destination address field
TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>=2)
TMR_W, $clog2(TIMEOUT+1), timeout counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
detect_add  in  1  FSM strobe: data_in holds header address this cycle
data_in  in  ADDR_W  destination address from packet header
write_enb_reg  in  1  FSM write request for current packet
read_enb  in  NUM_PORTS  per-port read enable from downstream
full  in  NUM_PORTS  per-FIFO full flags
empty  in  NUM_PORTS  per-FIFO empty flags
fifo_full  out  1  full flag of the currently addressed FIFO
vld_out  out  NUM_PORTS  per-port data-valid (not empty)
soft_reset  out  NUM_PORTS  per-port FIFO soft reset, 1-cycle pulse
write_enb  out  NUM_PORTS  one-hot FIFO write enable
addr_err  out  1  1-cycle pulse: latched address >= NUM_PORTS

Behaviour:
- Reset (async, reset=1):
  - addr_reg=0, addr_valid=0, all timers=0.
  - soft_reset=0, addr_err=0.
  - Hence write_enb=0 and fifo_full=0. vld_out stays combinational from empty.
- Address latch (registered):
  - On a rising edge with detect_add=1: addr_reg<=data_in; addr_valid<=(data_in<NUM_PORTS); addr_err<=(data_in>=NUM_PORTS).
  - Otherwise addr_reg and addr_valid hold, and addr_err<=0.
- write_enb (combinational): write_enb[i]=write_enb_reg & addr_valid & (addr_reg==i).
  - Zero-cycle latency from write_enb_reg.
  - Never more than one bit set.
  - detect_add and write_enb_reg high in the same cycle: write_enb decodes the OLD addr_reg; the new address takes effect next cycle.
- fifo_full (combinational): full[addr_reg] if addr_valid, else 0.
- vld_out[i] = ~empty[i] (combinational).
- Per-port timer i (independent):
  - Stall condition: stall_i = vld_out[i] & ~read_enb[i].
  - If !stall_i: timer<=0, soft_reset[i]<=0.
  - If stall_i and timer==TIMEOUT-1: soft_reset[i]<=1, timer<=0.
  - If stall_i otherwise: timer<=timer+1, soft_reset[i]<=0.
  - So soft_reset[i] is high for exactly the one cycle after the TIMEOUT-th consecutive stalled edge.
  - If the stall persists (FIFO not yet cleared), counting restarts from 0 and pulses again TIMEOUT cycles later.
  - read_enb[i] in any cycle clears the timer. A read on the very edge where timer==TIMEOUT-1 suppresses the pulse.
- Simultaneous stalls on several ports: each port times out independently; multiple soft_reset bits may be high together.
- Invalid address: write_enb stays 0 for the whole packet and fifo_full=0. Recovery requires the next detect_add with a valid address.
- Reset mid-operation: all of the above return to reset values immediately, independent of clock.
- No wrap-around: the timer never exceeds TIMEOUT-1.

Decomposition:
- Shared package router_pkg holds:
  - default NUM_PORTS, TIMEOUT;
  - addr_width function (clog2 with min 1);
  - localparam for max ports.
- One sub-module, router_sync_timer (clock, reset, vld, rd, soft_reset), parametrised by TIMEOUT/TMR_W. It is instantiated NUM_PORTS times via generate.
- Address latch and decode stay in the top.

Test Plan:
- Reset: assert reset mid-cycle with timers at 10 -> all outputs 0 asynchronously; timers restart from 0 after release.
- Address steer, NUM_PORTS=3:
  - detect_add=1, data_in=2 for one edge, then write_enb_reg=1 -> write_enb=3'b100.
  - full=3'b100 -> fifo_full=1; full=3'b011 -> fifo_full=0.
- Invalid address, NUM_PORTS=3: data_in=3 with detect_add -> addr_err pulses 1 cycle; write_enb=0 with write_enb_reg=1; then data_in=1 -> write_enb=3'b010.
- Same-cycle detect_add(data_in=0) and write_enb_reg, with previous addr 2 -> that cycle write_enb=3'b100; next cycle 3'b001.
- Timeout, TIMEOUT=30:
  - empty[0]=0, read_enb[0]=0 for 30 edges -> soft_reset[0]=1 for exactly 1 cycle after the 30th edge.
  - Held stalled -> second pulse 30 cycles later.
  - read_enb[0]=1 at edge 29 -> no pulse.
- Parametrisation: NUM_PORTS=5, TIMEOUT=4:
  - ports 1 and 4 stalled simultaneously -> soft_reset=5'b10010 after the 4th edge.
  - data_in=4 -> write_enb=5'b10000.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the parametrised router synchroniser and its per-port timers.
// Holds the default geometry and the address-width helper.
package router_pkg;

    localparam int DEFAULT_NUM_PORTS = 3;
    localparam int DEFAULT_TIMEOUT   = 30;
    localparam int MAX_PORTS         = 16;

    // $clog2 returns 0 for a single port; an address field must be at least one bit wide.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timer: pulses soft_reset for one cycle after TIMEOUT consecutive
// edges on which the port holds valid data that nobody reads.
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [TMR_W-1:0] timer;
    logic             stall;

    assign stall = vld & ~rd;

    // The counter restarts from zero on every pulse, so it never exceeds TIMEOUT-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            soft_reset <= 1'b0;
        end else if (!stall) begin
            timer      <= '0;
            soft_reset <= 1'b0;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            timer      <= '0;
            soft_reset <= 1'b1;
        end else begin
            timer      <= timer + TMR_W'(1);
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_param.sv
// Router synchroniser: latches the header address, steers the FSM write strobe to one
// output FIFO, reports its full flag, derives valid flags and times out stalled ports.
module router_sync_param
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int ADDR_W    = addr_width(NUM_PORTS),
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int TMR_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 detect_add,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 addr_err
);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("router_sync_param: NUM_PORTS out of range");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("router_sync_param: TIMEOUT must be at least 2");
    end

    localparam logic [31:0] NUM_PORTS_U = 32'(NUM_PORTS);

    logic [ADDR_W-1:0] addr_reg;
    logic              addr_valid;
    logic              data_in_ok;

    assign data_in_ok = (32'(data_in) < NUM_PORTS_U);

    // An out-of-range address is kept in addr_reg but marked invalid, which
    // blocks every write and masks fifo_full until the next good header.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            addr_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else if (detect_add) begin
            addr_reg   <= data_in;
            addr_valid <= data_in_ok;
            addr_err   <= ~data_in_ok;
        end else begin
            addr_err   <= 1'b0;
        end
    end

    // Decodes the registered address, so a header strobe in the same cycle as a
    // write still steers that write to the previous destination.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_valid && (32'(addr_reg) == 32'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .TMR_W   (TMR_W)
        ) u_timer (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[g]),
            .rd         (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_param.sv
// Directed bench for router_sync_param: a 3-port/TIMEOUT=30 instance and a
// 5-port/TIMEOUT=4 instance share clock and reset.
module tb_router_sync_param;

    logic clock;
    logic reset;

    // 3-port instance
    logic       detect_add3;
    logic [1:0] data_in3;
    logic       write_enb_reg3;
    logic [2:0] read_enb3, full3, empty3;
    logic       fifo_full3, addr_err3;
    logic [2:0] vld_out3, soft_reset3, write_enb3;

    // 5-port instance
    logic       detect_add5;
    logic [2:0] data_in5;
    logic       write_enb_reg5;
    logic [4:0] read_enb5, full5, empty5;
    logic       fifo_full5, addr_err5;
    logic [4:0] vld_out5, soft_reset5, write_enb5;

    int checks = 0;
    int errors = 0;

    router_sync_param #(.NUM_PORTS(3), .TIMEOUT(30)) u_dut3 (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add3),
        .data_in       (data_in3),
        .write_enb_reg (write_enb_reg3),
        .read_enb      (read_enb3),
        .full          (full3),
        .empty         (empty3),
        .fifo_full     (fifo_full3),
        .vld_out       (vld_out3),
        .soft_reset    (soft_reset3),
        .write_enb     (write_enb3),
        .addr_err      (addr_err3)
    );

    router_sync_param #(.NUM_PORTS(5), .TIMEOUT(4)) u_dut5 (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add5),
        .data_in       (data_in5),
        .write_enb_reg (write_enb_reg5),
        .read_enb      (read_enb5),
        .full          (full5),
        .empty         (empty5),
        .fifo_full     (fifo_full5),
        .vld_out       (vld_out5),
        .soft_reset    (soft_reset5),
        .write_enb     (write_enb5),
        .addr_err      (addr_err5)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        detect_add3    = 1'b0;
        data_in3       = '0;
        write_enb_reg3 = 1'b0;
        read_enb3      = '0;
        full3          = '0;
        empty3         = 3'b111;
        detect_add5    = 1'b0;
        data_in5       = '0;
        write_enb_reg5 = 1'b0;
        read_enb5      = '0;
        full5          = '0;
        empty5         = 5'b11111;

        // Reset values, before any clock edge
        #1;
        chk("rst_write_enb",  32'(write_enb3),  32'h0);
        chk("rst_fifo_full",  32'(fifo_full3),  32'h0);
        chk("rst_soft_reset", 32'(soft_reset3), 32'h0);
        chk("rst_addr_err",   32'(addr_err3),   32'h0);
        chk("rst_vld_out",    32'(vld_out3),    32'h0);
        #8 reset = 1'b0;

        // Address steer to port 2
        detect_add3 = 1'b1;
        data_in3    = 2'd2;
        step(1);
        detect_add3    = 1'b0;
        write_enb_reg3 = 1'b1;
        #1;
        chk("steer_write_enb", 32'(write_enb3), 32'h4);
        chk("steer_addr_err",  32'(addr_err3),  32'h0);
        full3 = 3'b100;
        #1;
        chk("steer_full_sel", 32'(fifo_full3), 32'h1);
        full3 = 3'b011;
        #1;
        chk("steer_full_other", 32'(fifo_full3), 32'h0);

        // Stall port 0 for 10 edges, then reset asynchronously mid-cycle
        full3  = 3'b100;
        empty3 = 3'b110;
        #1;
        chk("vld_out_port0", 32'(vld_out3), 32'h1);
        step(10);
        chk("pre_rst_soft", 32'(soft_reset3), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_write_enb", 32'(write_enb3),  32'h0);
        chk("async_rst_fifo_full", 32'(fifo_full3),  32'h0);
        chk("async_rst_soft",      32'(soft_reset3), 32'h0);
        chk("async_rst_vld_out",   32'(vld_out3),    32'h1);
        #1 reset = 1'b0;

        // Timer restarted from 0: pulse after the 30th stalled edge, again after the 60th
        step(29);
        chk("tmo_edge29", 32'(soft_reset3), 32'h0);
        chk("tmo_no_write_after_rst", 32'(write_enb3), 32'h0);
        step(1);
        chk("tmo_edge30_pulse", 32'(soft_reset3), 32'h1);
        step(1);
        chk("tmo_edge31_clear", 32'(soft_reset3), 32'h0);
        step(28);
        chk("tmo_edge59", 32'(soft_reset3), 32'h0);
        step(1);
        chk("tmo_edge60_pulse", 32'(soft_reset3), 32'h1);

        // A read on the edge where the timer would expire suppresses the pulse
        read_enb3 = 3'b001;
        step(1);
        chk("read_clears_soft", 32'(soft_reset3), 32'h0);
        read_enb3 = 3'b000;
        step(29);
        read_enb3 = 3'b001;
        step(1);
        chk("read_at_expiry", 32'(soft_reset3), 32'h0);
        read_enb3 = 3'b000;
        step(1);
        chk("read_at_expiry_next", 32'(soft_reset3), 32'h0);
        empty3 = 3'b111;

        // Invalid address 3
        write_enb_reg3 = 1'b0;
        detect_add3    = 1'b1;
        data_in3       = 2'd3;
        step(1);
        detect_add3 = 1'b0;
        chk("bad_addr_err_pulse", 32'(addr_err3), 32'h1);
        write_enb_reg3 = 1'b1;
        full3          = 3'b111;
        #1;
        chk("bad_addr_write_enb", 32'(write_enb3), 32'h0);
        chk("bad_addr_fifo_full", 32'(fifo_full3), 32'h0);
        step(1);
        chk("bad_addr_err_clear", 32'(addr_err3),  32'h0);
        chk("bad_addr_write_hold", 32'(write_enb3), 32'h0);
        detect_add3 = 1'b1;
        data_in3    = 2'd1;
        #1;
        chk("recover_same_cycle", 32'(write_enb3), 32'h0);
        step(1);
        detect_add3 = 1'b0;
        #1;
        chk("recover_write_enb", 32'(write_enb3), 32'h2);
        chk("recover_fifo_full", 32'(fifo_full3), 32'h1);
        chk("recover_addr_err",  32'(addr_err3),  32'h0);

        // Same-cycle header and write: old address 2 used, new address 0 next cycle
        detect_add3 = 1'b1;
        data_in3    = 2'd2;
        step(1);
        data_in3 = 2'd0;
        #1;
        chk("same_cycle_old_addr", 32'(write_enb3), 32'h4);
        step(1);
        detect_add3 = 1'b0;
        #1;
        chk("same_cycle_new_addr", 32'(write_enb3), 32'h1);
        write_enb_reg3 = 1'b0;
        full3          = '0;

        // 5 ports, TIMEOUT=4: ports 1 and 4 stalled together
        empty5 = 5'b01101;
        #1;
        chk("p5_vld_out", 32'(vld_out5), 32'h12);
        step(3);
        chk("p5_edge3", 32'(soft_reset5), 32'h0);
        step(1);
        chk("p5_edge4_pulse", 32'(soft_reset5), 32'h12);
        step(1);
        chk("p5_edge5_clear", 32'(soft_reset5), 32'h0);
        empty5 = 5'b11111;

        // 5 ports: address 4 valid, address 5 invalid
        detect_add5 = 1'b1;
        data_in5    = 3'd4;
        step(1);
        detect_add5    = 1'b0;
        write_enb_reg5 = 1'b1;
        full5          = 5'b10000;
        #1;
        chk("p5_write_enb_4", 32'(write_enb5), 32'h10);
        chk("p5_fifo_full_4", 32'(fifo_full5), 32'h1);
        chk("p5_addr_err_ok", 32'(addr_err5),  32'h0);
        detect_add5 = 1'b1;
        data_in5    = 3'd5;
        step(1);
        detect_add5 = 1'b0;
        #1;
        chk("p5_bad_addr_err",   32'(addr_err5),  32'h1);
        chk("p5_bad_write_enb",  32'(write_enb5), 32'h0);
        chk("p5_bad_fifo_full",  32'(fifo_full5), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
